// File: rtl/axi_burst_pkg.sv
// Shared types and default widths for the AXI write-burst beat tracker.
// Optional statistics are enabled with AXI_BURST_LAST_GEN_STATS_EN.
package axi_burst_pkg;

    localparam int AXI_CNT_W  = 8;
    localparam int AXI_XFER_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } burst_state_t;

endpackage

// File: rtl/axi_burst_stats.sv
// Burst completion counter and sticky protocol-error flag for axi_burst_last_gen.
// Only instantiated when AXI_BURST_LAST_GEN_STATS_EN is defined.
module axi_burst_stats #(
    parameter int XFER_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              handshake,
    input  logic              busy,
    input  logic              axi_last,
    output logic [XFER_W-1:0] bursts_done,
    output logic              proto_err
);

    logic [XFER_W-1:0] r_bursts;
    logic              r_err;

    // Count every accepted beat that closes a burst; a new transfer restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bursts <= '0;
        end else if (start) begin
            r_bursts <= '0;
        end else if (handshake && axi_last) begin
            r_bursts <= r_bursts + XFER_W'(1);
        end else begin
            r_bursts <= r_bursts;
        end
    end

    // Sticky flag: a beat offered while idle or on top of a start pulse is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (handshake && (start || !busy)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign bursts_done = r_bursts;
    assign proto_err   = r_err;

endmodule

// File: rtl/axi_burst_last_gen.sv
// Runtime-configurable AXI write-burst beat tracker generating WLAST.
// Define AXI_BURST_LAST_GEN_STATS_EN to add bursts_done / proto_err outputs.
module axi_burst_last_gen
    import axi_burst_pkg::*;
#(
    parameter int CNT_W  = AXI_CNT_W,
    parameter int XFER_W = AXI_XFER_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [XFER_W-1:0] xfer_beats,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              handshake,
    input  logic              last,
    output logic              axi_last,
    output logic              busy,
    output logic              xfer_done,
    output logic [CNT_W-1:0]  beat_idx
`ifdef AXI_BURST_LAST_GEN_STATS_EN
    ,
    output logic [XFER_W-1:0] bursts_done,
    output logic              proto_err
`endif
);

    localparam logic [XFER_W-1:0] REM_ONE = XFER_W'(1);

    burst_state_t      r_state;
    logic [CNT_W-1:0]  r_beat;
    logic [CNT_W-1:0]  r_len;
    logic [XFER_W-1:0] r_rem;
    logic              r_done;

    logic w_busy;
    logic w_rem_one;
    logic w_axi_last;

    assign w_busy    = (r_state == ST_ACTIVE);
    assign w_rem_one = (r_rem == REM_ONE);
    // The remaining-count term closes a short final burst; last passes through even when idle.
    assign w_axi_last = (w_busy & ((r_beat == r_len) | w_rem_one)) | last;

    // Transfer state: start has priority and drops any coincident beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_len   <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_len  <= burst_len;
            r_rem  <= xfer_beats;
            r_beat <= '0;
            if (xfer_beats != '0) begin
                r_state <= ST_ACTIVE;
                r_done  <= 1'b0;
            end else begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
            end
        end else if (handshake && w_busy) begin
            r_rem  <= r_rem - XFER_W'(1);
            r_beat <= w_axi_last ? '0 : (r_beat + CNT_W'(1));
            if (w_rem_one || last) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
            end else begin
                r_state <= r_state;
                r_done  <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign axi_last  = w_axi_last;
    assign busy      = w_busy;
    assign xfer_done = r_done;
    assign beat_idx  = r_beat;

`ifdef AXI_BURST_LAST_GEN_STATS_EN
    axi_burst_stats #(
        .XFER_W (XFER_W)
    ) u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .handshake   (handshake),
        .busy        (w_busy),
        .axi_last    (w_axi_last),
        .bursts_done (bursts_done),
        .proto_err   (proto_err)
    );
`endif

endmodule

// File: doc/axi_burst_last_gen.md
# axi_burst_last_gen

Runtime-configurable AXI write-burst beat tracker for the decompressor's write-back path. It replaces the fixed-length burst counter with three additions: burst length and total transfer length are loaded per transfer, the final partial burst is handled, and early termination is supported. WLAST is generated combinationally on the correct beat. It sits between the output data FIFO and the AXI write-data channel, watching `valid & ready` handshakes.

## Interface
Parameters:
- `CNT_W`, 8: beat-in-burst counter width; maximum burst is 2^CNT_W beats.
- `XFER_W`, 32: total-transfer beat counter width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse; loads `xfer_beats` and `burst_len`, begins a transfer.
- `xfer_beats`  in  XFER_W  total beats in the transfer; sampled on `start`.
- `burst_len`  in  CNT_W  beats per burst minus 1 (AXI LEN encoding); sampled on `start`.
- `handshake`  in  1  W-channel beat accepted (`wvalid & wready`).
- `last`  in  1  upstream early-termination marker for the current beat.
- `axi_last`  out  1  WLAST for the beat currently presented.
- `busy`  out  1  transfer active.
- `xfer_done`  out  1  one-cycle pulse when the transfer completes.
- `beat_idx`  out  CNT_W  index of the current beat within its burst.

## Operation
- FSM states: IDLE and ACTIVE.
- Registered state: `beat_q` (CNT_W bits), `rem_q` (XFER_W bits), `len_q` (CNT_W bits).
- Events have this priority: reset, then `start`, then `handshake`.
- `start` in any state:
  - latches `len_q <= burst_len`, `rem_q <= xfer_beats`, `beat_q <= 0`.
  - enters ACTIVE if `xfer_beats != 0`.
  - otherwise stays in or returns to IDLE and pulses `xfer_done`.
  - a handshake in the same cycle is dropped and not counted.
  - `start` while ACTIVE aborts the old transfer without a `xfer_done` pulse.
- `handshake` in ACTIVE:
  - `rem_q` decrements.
  - if `axi_last` is high, `beat_q <= 0`; otherwise `beat_q` increments.
  - if `rem_q == 1` or `last` is high, go to IDLE and pulse `xfer_done`.
- `handshake` in IDLE is ignored; no state change.
- `axi_last = (busy & ((beat_q == len_q) | (rem_q == 1))) | last`.
  - `last` passes through in every state, for compatibility with existing upstream logic.
- Final partial burst: the `rem_q == 1` term closes it regardless of `beat_q`.
- Width rules:
  - `beat_q` never exceeds `len_q`.
  - `len_q` = 2^CNT_W−1 wraps `beat_q` to 0 naturally.
  - `rem_q` never underflows, because ACTIVE implies `rem_q >= 1`.

## Timing
- Reset values: `busy` 0, `xfer_done` 0, `beat_idx` 0, state IDLE. `axi_last` is 0 unless `last` is high.
- `start` in cycle N gives `busy` = 1 in cycle N+1. The first countable beat is in N+1.
- `axi_last` is combinational from registers plus `last`, so it is valid in the same cycle as the beat it marks.
- On the final handshake in cycle M, `busy` drops and `xfer_done` is high in cycle M+1, for exactly one cycle.
- For `xfer_beats == 0`, `xfer_done` pulses in cycle N+1 and `busy` stays 0.
- Reset asserted mid-transfer clears all state immediately, without waiting for a clock edge.

## Configuration
- `AXI_BURST_LAST_GEN_STATS_EN` defined adds two outputs:
  - `bursts_done` [XFER_W-1:0]: increments on every handshake with `axi_last` high; clears on `start`.
  - `proto_err` (sticky): set by a handshake in IDLE or a handshake coincident with `start`; cleared only by reset.
- Macro undefined: neither port exists, and no counter logic is generated.

## Structure
- Shared package `axi_burst_pkg` holds:
  - the state enum (IDLE, ACTIVE).
  - default constants `AXI_CNT_W = 8` and `AXI_XFER_W = 32`.
- One natural sub-module, `axi_burst_stats`: the statistics counter and error flag, instantiated only under the macro.

## Test plan
- `burst_len` = 3, `xfer_beats` = 8, back-to-back handshakes → `axi_last` on beats 4 and 8; `xfer_done` one cycle after beat 8.
- `burst_len` = 3, `xfer_beats` = 6, `handshake` gapped with 2-cycle bubbles → `axi_last` on beats 4 and 6 only; `beat_idx` holds during bubbles.
- `xfer_beats` = 16, `last` on beat 2 → `axi_last` on beat 2; `busy` drops; `xfer_done` pulses; `beat_idx` = 0.
- `start` with `xfer_beats` = 2, `burst_len` = 0, at beat 5 of a running transfer, with a coincident handshake →
  - handshake not counted.
  - `axi_last` on both following beats.
  - a single `xfer_done` after the second beat.
  - with the macro defined, `proto_err` = 1.
- `start` with `xfer_beats` = 0 → `busy` stays 0; `xfer_done` = 1 in the next cycle.
- `rst_n` low mid-burst, between clock edges → `busy`, `beat_idx` and `axi_last` go to 0 immediately.
